// File: rtl/slow_cfg_pkg.sv
// Shared types and constants for the slow-access configuration timer.
package slow_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_EXPIRED = 2'd2
  } tmo_state_e;

  // Bit positions inside the Slow[] vector
  localparam int SLOW_IACK    = 6;
  localparam int SLOW_VIA     = 5;
  localparam int SLOW_IWM     = 4;
  localparam int SLOW_SCC     = 3;
  localparam int SLOW_SCSI    = 2;
  localparam int SLOW_SND     = 1;
  localparam int SLOW_CLKGATE = 0;

  localparam int         DEF_NCH      = 7;
  localparam int         DEF_TW       = 4;
  localparam logic [6:0] DEF_RST_SLOW = 7'b1111010;
  localparam logic [3:0] DEF_RST_TO   = 4'hF;

endpackage

// File: rtl/slow_timeout_fsm.sv
// Runtime timeout engine: counts prescaler ticks while a slow access is
// outstanding and flags expiry until the access is dropped.
module slow_timeout_fsm
  import slow_cfg_pkg::*;
#(
  parameter int TW = DEF_TW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          slow_acc,
  input  logic          tick,
  input  logic [TW-1:0] timeout,
  output logic [TW-1:0] cnt,
  output logic          timed_out,
  output logic          exp_pulse
);

  tmo_state_e    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          acc_r_q, acc_r_d;
  logic          timed_out_q, timed_out_d;
  logic          exp_pulse_q, exp_pulse_d;
  logic          start;

  assign start = slow_acc && !acc_r_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_r_d     = slow_acc;
    timed_out_d = timed_out_q;
    exp_pulse_d = 1'b0;

    case (state_q)
      ST_COUNT: begin
        // Dropping the access wins over a coincident expiring tick
        if (!slow_acc) begin
          state_d = ST_IDLE;
        end else if (tick && (cnt_q == TW'(1))) begin
          cnt_d       = '0;
          timed_out_d = 1'b1;
          exp_pulse_d = 1'b1;
          state_d     = ST_EXPIRED;
        end else if (tick && (cnt_q >= TW'(2))) begin
          cnt_d = cnt_q - TW'(1);
        end
      end

      ST_EXPIRED: begin
        if (!slow_acc) begin
          timed_out_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        // IDLE, and the unused encoding 3 which behaves as IDLE
        state_d     = ST_IDLE;
        timed_out_d = 1'b0;
        if (start && (timeout != '0)) begin
          cnt_d   = timeout;
          state_d = ST_COUNT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_r_q     <= 1'b0;
      timed_out_q <= 1'b0;
      exp_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_r_q     <= acc_r_d;
      timed_out_q <= timed_out_d;
      exp_pulse_q <= exp_pulse_d;
    end
  end

  assign cnt       = cnt_q;
  assign timed_out = timed_out_q;
  assign exp_pulse = exp_pulse_q;

endmodule

// File: rtl/slow_cfg_timer.sv
// Slow-access configuration register with single-commit write detection and
// a per-access timeout engine for the bus-cycle controller.
module slow_cfg_timer
  import slow_cfg_pkg::*;
#(
  parameter int             NCH      = DEF_NCH,
  parameter int             TW       = DEF_TW,
  parameter logic [NCH-1:0] RST_SLOW = NCH'(DEF_RST_SLOW),
  parameter logic [TW-1:0]  RST_TO   = TW'(DEF_RST_TO)
) (
  input  logic              CLK,
  input  logic              POR,
  input  logic              BACT,
  input  logic              SetCSWR,
  input  logic [NCH+TW:1]   A,
  input  logic              SlowAcc,
  input  logic              Tick,
  output logic [NCH-1:0]    Slow,
  output logic [TW-1:0]     SlowTimeout,
  output logic [TW-1:0]     Cnt,
  output logic              TimedOut,
  output logic              ExpPulse
);

  logic           wr_q, wr_d;
  logic           wr2_q, wr2_d;
  logic           commit;
  logic [NCH-1:0] slow_q, slow_d;
  logic [TW-1:0]  tout_q, tout_d;

  // One commit per strobe, however long BACT and SetCSWR stay asserted
  assign commit = wr_q && !wr2_q;

  always_comb begin
    wr_d   = BACT && SetCSWR;
    wr2_d  = wr_q;
    slow_d = slow_q;
    tout_d = tout_q;
    if (commit) begin
      slow_d = A[NCH:1];
      tout_d = A[NCH+TW:NCH+1];
    end
  end

  always_ff @(posedge CLK) begin
    if (POR) begin
      wr_q   <= 1'b0;
      wr2_q  <= 1'b0;
      slow_q <= RST_SLOW;
      tout_q <= RST_TO;
    end else begin
      wr_q   <= wr_d;
      wr2_q  <= wr2_d;
      slow_q <= slow_d;
      tout_q <= tout_d;
    end
  end

  // A commit mid-access only changes the code used by the next access
  slow_timeout_fsm #(
    .TW(TW)
  ) u_fsm (
    .clk      (CLK),
    .rst      (POR),
    .slow_acc (SlowAcc),
    .tick     (Tick),
    .timeout  (tout_q),
    .cnt      (Cnt),
    .timed_out(TimedOut),
    .exp_pulse(ExpPulse)
  );

  assign Slow        = slow_q;
  assign SlowTimeout = tout_q;

endmodule
